// File: rtl/uart_si_pkg.sv
// Shared definitions for the UART simple-interface master and its neighbours:
// register map, status bit positions, control word layout and master FSM states.
package uart_si_pkg;

  localparam logic [3:0] UART_CR_A   = 4'h0;
  localparam logic [3:0] UART_DATA_A = 4'h4;
  localparam logic [3:0] UART_DIV_A  = 4'h8;

  localparam int ST_RX_AV   = 3;
  localparam int ST_TX_BUSY = 2;

  // Control register layout, MSB first (8'hA3 = lvl 2/2, no full flags, rx+tx enabled)
  typedef struct packed {
    logic [1:0] rx_fifo_lvl;
    logic [1:0] tx_fifo_lvl;
    logic       rx_full;
    logic       tx_full;
    logic       rec_en;
    logic       tr_en;
  } uart_cr_t;

  typedef enum logic [2:0] {
    INIT_CR  = 3'd0,
    INIT_DIV = 3'd1,
    POLL     = 3'd2,
    RD_DATA  = 3'd3,
    WR_DATA  = 3'd4
  } si_state_e;

  // Widen a control word to the 32-bit bus
  function automatic logic [31:0] cr_to_bus(input uart_cr_t cr);
    return {24'd0, cr};
  endfunction

endpackage

// File: rtl/uart_si_rx_buf.sv
// One-entry valid/ready holding register for bytes read from the UART.
// A refill has priority over a same-cycle handshake so no byte is lost.
module uart_si_rx_buf (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_data
);

  logic       r_valid;
  logic [7:0] r_data;

  // Hold one byte until the consumer accepts it; refill wins over clear
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_valid <= 1'b0;
      r_data  <= 8'd0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
      r_data  <= r_data;
    end else begin
      r_valid <= r_valid;
      r_data  <= r_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/uart_si_master.sv
// Bus master for the UART simple interface: configures CR and DIV once after
// reset, then polls status, moving tx stream bytes to DATA and DATA bytes to
// the rx stream. Bus outputs are decoded from the state register and forced
// to zero while reset is asserted.
module uart_si_master
  import uart_si_pkg::*;
#(
  parameter logic [7:0]  CR_INIT  = 8'hA3,
  parameter logic [15:0] BAUD_DIV = 16'h0200
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [3:0]  si_addr,
  output logic        si_re,
  output logic        si_we,
  output logic [31:0] si_wd,
  input  logic [31:0] si_rd,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        init_done
);

  si_state_e   r_state;
  si_state_e   w_state_nxt;
  logic [3:0]  w_addr;
  logic        w_re;
  logic        w_we;
  logic [31:0] w_wd;
  logic        w_tx_ready;
  logic        w_load;
  logic        w_rx_valid;
  logic        r_init_done;
  logic        w_unused_rd;

  // Only status bits and the data byte of the read bus are meaningful here
  assign w_unused_rd = ^{si_rd[31:8]};

  // State register; reset restarts the configuration sequence
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state <= INIT_CR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sticky flag: set once the DIV write has been issued
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_init_done <= 1'b0;
    end else if (r_state == INIT_DIV) begin
      r_init_done <= 1'b1;
    end else begin
      r_init_done <= r_init_done;
    end
  end

  // Next-state and bus decode; rx is served before tx in POLL
  always_comb begin
    w_state_nxt = r_state;
    w_addr      = 4'h0;
    w_re        = 1'b0;
    w_we        = 1'b0;
    w_wd        = 32'd0;
    w_tx_ready  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      INIT_CR: begin
        w_we        = 1'b1;
        w_addr      = UART_CR_A;
        w_wd        = cr_to_bus(uart_cr_t'(CR_INIT));
        w_state_nxt = INIT_DIV;
      end
      INIT_DIV: begin
        w_we        = 1'b1;
        w_addr      = UART_DIV_A;
        w_wd        = {16'd0, BAUD_DIV};
        w_state_nxt = POLL;
      end
      POLL: begin
        w_re   = 1'b1;
        w_addr = UART_CR_A;
        if (si_rd[ST_RX_AV] && !w_rx_valid) begin
          w_state_nxt = RD_DATA;
        end else if (tx_valid && !si_rd[ST_TX_BUSY]) begin
          w_state_nxt = WR_DATA;
        end else begin
          w_state_nxt = POLL;
        end
      end
      RD_DATA: begin
        w_re        = 1'b1;
        w_addr      = UART_DATA_A;
        w_load      = 1'b1;
        w_state_nxt = POLL;
      end
      WR_DATA: begin
        w_we        = 1'b1;
        w_addr      = UART_DATA_A;
        w_wd        = {24'd0, tx_data};
        w_tx_ready  = 1'b1;
        w_state_nxt = POLL;
      end
      default: begin
        w_state_nxt = INIT_CR;
      end
    endcase
  end

  uart_si_rx_buf u_rx_buf (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_load & ~rstn),
    .i_data  (si_rd[7:0]),
    .i_ready (rx_ready),
    .o_valid (w_rx_valid),
    .o_data  (rx_data)
  );

  assign si_addr   = rstn ? 4'h0  : w_addr;
  assign si_re     = w_re & ~rstn;
  assign si_we     = w_we & ~rstn;
  assign si_wd     = rstn ? 32'd0 : w_wd;
  assign tx_ready  = w_tx_ready & ~rstn;
  assign rx_valid  = w_rx_valid;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_uart_si_master.sv
// Self-checking bench for uart_si_master: a behavioural UART stub (status,
// rx FIFO, optional tx->rx loopback) plus random stream producers/consumers.
module tb_uart_si_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  si_addr;
  logic        si_re;
  logic        si_we;
  logic [31:0] si_wd;
  logic [31:0] si_rd;
  logic [7:0]  tx_data = 8'd0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        init_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_si_master dut (
    .clk(clk), .rstn(rstn), .si_addr(si_addr), .si_re(si_re), .si_we(si_we),
    .si_wd(si_wd), .si_rd(si_rd), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .init_done(init_done)
  );

  // Single comparison point: count it and report mismatches
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- UART stub ----------------
  logic [7:0] fifo_mem [0:255];
  logic [7:0] fifo_wr = 8'd0;
  logic [7:0] fifo_rd = 8'd0;
  logic       loopback = 1'b0;
  logic       busy_man = 1'b0;
  logic       busy_rand = 1'b0;
  logic       busy_rnd = 1'b0;
  logic       tx_busy;
  logic [7:0] inj_mem [0:15];
  int         inj_cnt = 0;
  int         inj_taken = 0;
  int         n_reads = 0;
  int         n_writes = 0;
  logic [7:0] last_wr = 8'd0;
  int         cyc = 0;
  logic [7:0] ev_kind [0:1023];
  int         ev_cyc [0:1023];
  int         ev_n = 0;
  logic       prev_poll = 1'b0;
  logic       poll_busy = 1'b0;
  logic       poll_rxav = 1'b0;

  assign tx_busy = busy_rand ? busy_rnd : busy_man;

  // Stub read data: status at CR, head of rx FIFO at DATA
  always_comb begin
    si_rd = 32'd0;
    if (si_re && si_addr == 4'h0) si_rd = {28'd0, (fifo_rd != fifo_wr), tx_busy, 2'b00};
    else if (si_re && si_addr == 4'h4) si_rd = {24'd0, fifo_mem[fifo_rd]};
  end

  // Stub bus side effects and protocol checks on DATA accesses
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rstn) begin
      prev_poll <= 1'b0;
    end else begin
      prev_poll <= si_re && si_addr == 4'h0;
      if (si_re && si_addr == 4'h0) begin
        poll_busy <= tx_busy;
        poll_rxav <= (fifo_rd != fifo_wr);
      end
      if (si_re && si_addr == 4'h4) begin
        check_eq("rd_after_poll", {31'd0, prev_poll}, 32'd1);
        check_eq("rd_rx_avail", {31'd0, poll_rxav}, 32'd1);
        if (fifo_rd != fifo_wr) fifo_rd <= fifo_rd + 8'd1;
        n_reads <= n_reads + 1;
        if (ev_n < 1024) begin ev_kind[ev_n] <= 8'h52; ev_cyc[ev_n] <= cyc; ev_n <= ev_n + 1; end
      end else if (si_we && si_addr == 4'h4) begin
        check_eq("wr_after_poll", {31'd0, prev_poll}, 32'd1);
        check_eq("wr_while_busy", {31'd0, poll_busy}, 32'd0);
        n_writes <= n_writes + 1;
        last_wr  <= si_wd[7:0];
        if (ev_n < 1024) begin ev_kind[ev_n] <= 8'h57; ev_cyc[ev_n] <= cyc; ev_n <= ev_n + 1; end
      end
    end
    if (loopback && !rstn && si_we && si_addr == 4'h4) begin
      fifo_mem[fifo_wr] <= si_wd[7:0];
      fifo_wr <= fifo_wr + 8'd1;
    end else if (inj_taken < inj_cnt) begin
      fifo_mem[fifo_wr] <= inj_mem[inj_taken[3:0]];
      fifo_wr <= fifo_wr + 8'd1;
      inj_taken <= inj_taken + 1;
    end
  end

  // ---------------- rx consumer and recorder ----------------
  logic       rdy_man = 1'b0;
  logic       cons_rand = 1'b0;
  logic       rdy_rnd = 1'b0;
  logic [7:0] got_mem [0:255];
  int         got_n = 0;

  assign rx_ready = cons_rand ? rdy_rnd : rdy_man;

  // Random back-pressure and busy patterns, changed away from the active edge
  always @(negedge clk) begin
    rdy_rnd  <= ($urandom_range(0, 1) == 1);
    busy_rnd <= ($urandom_range(0, 3) == 0);
  end

  // Record every accepted rx byte
  always @(posedge clk) begin
    if (!rstn && rx_valid && rx_ready) begin
      got_mem[got_n[7:0]] <= rx_data;
      got_n <= got_n + 1;
    end
  end

  // Bus invariants sampled mid-cycle
  always @(negedge clk) begin
    if (!rstn) begin
      check_eq("re_we_excl", {31'd0, si_re & si_we}, 32'd0);
      if (si_re) check_eq("wd_on_read", si_wd, 32'd0);
    end
  end

  // ---------------- helpers ----------------
  task automatic check_outs_zero(input string tag);
    check_eq({tag, "_we"}, {31'd0, si_we}, 32'd0);
    check_eq({tag, "_re"}, {31'd0, si_re}, 32'd0);
    check_eq({tag, "_addr"}, {28'd0, si_addr}, 32'd0);
    check_eq({tag, "_wd"}, si_wd, 32'd0);
    check_eq({tag, "_txrdy"}, {31'd0, tx_ready}, 32'd0);
    check_eq({tag, "_rxv"}, {31'd0, rx_valid}, 32'd0);
    check_eq({tag, "_rxd"}, {24'd0, rx_data}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, init_done}, 32'd0);
  endtask

  // Called right after reset release at a negedge
  task automatic check_init_seq(input string tag);
    #1;
    check_eq({tag, "_cr_we"}, {31'd0, si_we}, 32'd1);
    check_eq({tag, "_cr_addr"}, {28'd0, si_addr}, 32'h0);
    check_eq({tag, "_cr_wd"}, si_wd, 32'hA3);
    check_eq({tag, "_cr_done"}, {31'd0, init_done}, 32'd0);
    @(negedge clk);
    check_eq({tag, "_div_we"}, {31'd0, si_we}, 32'd1);
    check_eq({tag, "_div_addr"}, {28'd0, si_addr}, 32'h8);
    check_eq({tag, "_div_wd"}, si_wd, 32'h200);
    check_eq({tag, "_div_done"}, {31'd0, init_done}, 32'd0);
    @(negedge clk);
    check_eq({tag, "_poll_re"}, {31'd0, si_re}, 32'd1);
    check_eq({tag, "_poll_we"}, {31'd0, si_we}, 32'd0);
    check_eq({tag, "_poll_addr"}, {28'd0, si_addr}, 32'h0);
    check_eq({tag, "_done"}, {31'd0, init_done}, 32'd1);
  endtask

  // Offer one byte and wait (bounded) for the consuming pulse
  task automatic send_byte(input logic [7:0] b, input string tag);
    logic ok;
    ok = 1'b0;
    tx_data  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_ready) begin ok = 1'b1; break; end
    end
    check_eq({tag, "_accept"}, {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  logic [7:0] exp_q [$];
  string      msg;
  int         base, w0, r0, e0, p;
  logic       ok;

  initial begin
    #2 rstn = 1'b1;
    @(negedge clk);
    check_outs_zero("rst");

    // 1: init sequence after release
    @(negedge clk);
    rstn = 1'b0;
    check_init_seq("init");

    // 2: loopback stream with random busy and back-pressure
    loopback = 1'b1; busy_rand = 1'b1; cons_rand = 1'b1;
    base = got_n;
    msg = "Hello World!\n";
    for (int i = 0; i < msg.len(); i++) exp_q.push_back(msg[i]);
    for (int i = 0; i < 20; i++) exp_q.push_back(8'($urandom_range(0, 255)));
    foreach (exp_q[i]) send_byte(exp_q[i], "loop");
    for (int i = 0; i < 2000 && (got_n - base) < exp_q.size(); i++) @(negedge clk);
    check_eq("loop_count", got_n - base, exp_q.size());
    foreach (exp_q[i]) check_eq("loop_byte", {24'd0, got_mem[8'(base + i)]}, {24'd0, exp_q[i]});
    loopback = 1'b0; busy_rand = 1'b0; cons_rand = 1'b0;
    repeat (4) @(negedge clk);

    // 3: tx held off while busy, exactly one write once free
    busy_man = 1'b1; tx_data = 8'h3C; tx_valid = 1'b1;
    w0 = n_writes; p = 0;
    repeat (20) begin @(negedge clk); if (tx_ready) p++; end
    check_eq("busy_no_write", n_writes - w0, 0);
    check_eq("busy_no_ready", p, 0);
    busy_man = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_ready) begin p++; @(posedge clk); #1 tx_valid = 1'b0; end
    end
    check_eq("free_one_write", n_writes - w0, 1);
    check_eq("free_one_ready", p, 1);
    check_eq("free_wr_data", {24'd0, last_wr}, 32'h3C);

    // 4: rx buffer full blocks further reads
    r0 = n_reads;
    inj_mem[inj_cnt[3:0]] = 8'h55; inj_mem[4'(inj_cnt + 1)] = 8'h66;
    inj_cnt = inj_cnt + 2;
    repeat (20) @(negedge clk);
    check_eq("rxfull_reads", n_reads - r0, 1);
    check_eq("rxfull_valid", {31'd0, rx_valid}, 32'd1);
    check_eq("rxfull_data", {24'd0, rx_data}, 32'h55);
    rdy_man = 1'b1; @(posedge clk); #1 rdy_man = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("rx_acc_byte", {24'd0, got_mem[8'(got_n - 1)]}, 32'h55);
    check_eq("rx_next_reads", n_reads - r0, 2);
    check_eq("rx_next_valid", {31'd0, rx_valid}, 32'd1);
    check_eq("rx_next_data", {24'd0, rx_data}, 32'h66);
    rdy_man = 1'b1; @(posedge clk); #1 rdy_man = 1'b0;
    @(negedge clk);
    check_eq("rx_drained", {31'd0, rx_valid}, 32'd0);

    // 5: rx and tx pending in the same POLL -> read first
    e0 = ev_n;
    inj_mem[inj_cnt[3:0]] = 8'h77; inj_cnt = inj_cnt + 1;
    @(posedge clk);
    #1;
    send_byte(8'h88, "prio");
    repeat (3) @(negedge clk);
    check_eq("prio_events", ev_n - e0, 2);
    check_eq("prio_first_rd", {24'd0, ev_kind[e0]}, 32'h52);
    check_eq("prio_then_wr", {24'd0, ev_kind[e0 + 1]}, 32'h57);
    check_eq("prio_gap", ev_cyc[e0 + 1] - ev_cyc[e0], 2);
    check_eq("prio_wr_data", {24'd0, last_wr}, 32'h88);
    check_eq("prio_rx_data", {24'd0, rx_data}, 32'h77);
    rdy_man = 1'b1; @(posedge clk); #1 rdy_man = 1'b0;

    // 6: reset asserted during WR_DATA
    tx_data = 8'h99; tx_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_ready) begin ok = 1'b1; break; end
    end
    check_eq("rst_wr_reached", {31'd0, ok}, 32'd1);
    rstn = 1'b1;
    #1 check_outs_zero("midrst");
    @(posedge clk);
    #1 check_outs_zero("midrst_hold");
    tx_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    check_init_seq("reinit");

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
